// File: rtl/id_ex_reg.sv
// id_ex_reg: ID/EX pipeline register with flush, stall and load-use bubble insertion.
// Define ID_EX_HAZARD_DETECT_EN to enable load-use detection and the bubble counter.
module id_ex_reg (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid_i,
  input  logic [15:0] id_ctrl_i,
  input  logic [31:0] id_pc_i,
  input  logic [31:0] id_rs_data_i,
  input  logic [31:0] id_rt_data_i,
  input  logic [31:0] id_imm_i,
  input  logic [4:0]  id_rs_i,
  input  logic [4:0]  id_rt_i,
  input  logic [4:0]  id_rd_i,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic        ex_valid_o,
  output logic [15:0] ex_ctrl_o,
  output logic [31:0] ex_pc_o,
  output logic [31:0] ex_rs_data_o,
  output logic [31:0] ex_rt_data_o,
  output logic [31:0] ex_imm_o,
  output logic [4:0]  ex_rs_o,
  output logic [4:0]  ex_rt_o,
  output logic [4:0]  ex_dest_o,
  output logic        stall_o,
  output logic [15:0] bubble_cnt_o
);
  logic       hazard, load, kill;
  logic [4:0] dest;
`ifdef ID_EX_HAZARD_DETECT_EN
  // rt only matters when the decode instruction reads it as a register (no immediate, or a store)
  assign hazard = ex_valid_o & ex_ctrl_o[13] & (ex_dest_o != 5'd0) & id_valid_i &
                  ((ex_dest_o == id_rs_i) | ((ex_dest_o == id_rt_i) & (~id_ctrl_i[10] | id_ctrl_i[11])));
  always_ff @(posedge clk or posedge reset)
    if (reset) bubble_cnt_o <= '0;
    else if (~flush_i & ~stall_i & hazard & ~&bubble_cnt_o) bubble_cnt_o <= bubble_cnt_o + 16'd1;
`else
  assign hazard = 1'b0;
  assign bubble_cnt_o = '0;
`endif
  assign stall_o = ~flush_i & (stall_i | hazard);
  assign load = ~flush_i & ~stall_i & ~hazard;
  assign kill = flush_i | (~stall_i & hazard);
  assign dest = (id_valid_i & id_ctrl_i[9]) ? (id_ctrl_i[15] ? id_rd_i : id_rt_i) : 5'd0;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ex_valid_o <= 1'b0;
      ex_ctrl_o  <= '0;
      ex_dest_o  <= '0;
    end else if (kill) begin
      ex_valid_o <= 1'b0;
      ex_ctrl_o  <= '0;
      ex_dest_o  <= '0;
    end else if (load) begin
      ex_valid_o <= id_valid_i;
      ex_ctrl_o  <= id_valid_i ? id_ctrl_i : 16'd0;
      ex_dest_o  <= dest;
    end
  // data path only moves on a real load; bubbles and flushes leave it alone
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ex_pc_o      <= '0;
      ex_rs_data_o <= '0;
      ex_rt_data_o <= '0;
      ex_imm_o     <= '0;
      ex_rs_o      <= '0;
      ex_rt_o      <= '0;
    end else if (load) begin
      ex_pc_o      <= id_pc_i;
      ex_rs_data_o <= id_rs_data_i;
      ex_rt_data_o <= id_rt_data_i;
      ex_imm_o     <= id_imm_i;
      ex_rs_o      <= id_rs_i;
      ex_rt_o      <= id_rt_i;
    end
endmodule

// File: tb/tb_id_ex_reg.sv
// tb_id_ex_reg: vector table, directed corner sequences and randomized checks against a reference model.
module tb_id_ex_reg;
  logic clk = 1'b0, reset;
  logic id_valid_i, stall_i, flush_i;
  logic [15:0] id_ctrl_i;
  logic [31:0] id_pc_i, id_rs_data_i, id_rt_data_i, id_imm_i;
  logic [4:0] id_rs_i, id_rt_i, id_rd_i;
  logic ex_valid_o, stall_o;
  logic [15:0] ex_ctrl_o, bubble_cnt_o;
  logic [31:0] ex_pc_o, ex_rs_data_o, ex_rt_data_o, ex_imm_o;
  logic [4:0] ex_rs_o, ex_rt_o, ex_dest_o;
  int checks = 0, errors = 0;
`ifdef ID_EX_HAZARD_DETECT_EN
  localparam bit HZ = 1'b1;
`else
  localparam bit HZ = 1'b0;
`endif
  localparam logic [15:0] ADD = 16'h8200, LDW = 16'h3601, STW = 16'h0C01, ADDI = 16'h0600;

  id_ex_reg dut (.clk(clk), .reset(reset), .id_valid_i(id_valid_i), .id_ctrl_i(id_ctrl_i),
    .id_pc_i(id_pc_i), .id_rs_data_i(id_rs_data_i), .id_rt_data_i(id_rt_data_i), .id_imm_i(id_imm_i),
    .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_rd_i(id_rd_i), .stall_i(stall_i), .flush_i(flush_i),
    .ex_valid_o(ex_valid_o), .ex_ctrl_o(ex_ctrl_o), .ex_pc_o(ex_pc_o), .ex_rs_data_o(ex_rs_data_o),
    .ex_rt_data_o(ex_rt_data_o), .ex_imm_o(ex_imm_o), .ex_rs_o(ex_rs_o), .ex_rt_o(ex_rt_o),
    .ex_dest_o(ex_dest_o), .stall_o(stall_o), .bubble_cnt_o(bubble_cnt_o));

  always #5 clk = ~clk;

  typedef struct {
    logic valid; logic [15:0] ctrl; logic [31:0] pc, rsd, rtd, imm;
    logic [4:0] rs, rt, dest; logic [15:0] cnt;
  } st_t;
  st_t m;

  typedef struct {
    logic v; logic [15:0] ctrl; logic [31:0] pc; logic [4:0] rs, rt, rd; logic st, fl;
    logic e_valid; logic [31:0] e_pc; logic [4:0] e_dest; logic e_stall;
  } vec_t;
  vec_t tbl [9];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  // load-use rule: loading instruction in EX writes a register the decode instruction reads
  function automatic logic m_hazard();
    logic reads_rt = !id_ctrl_i[10] || id_ctrl_i[11];
    return HZ && m.valid && m.ctrl[13] && m.dest != 0 && id_valid_i &&
           (m.dest == id_rs_i || (m.dest == id_rt_i && reads_rt));
  endfunction

  task automatic m_clear();
    m = '{1'b0, 16'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'h0, 5'h0, 5'h0, 16'h0};
  endtask

  task automatic check_state(input string n);
    chk({n, " valid"}, ex_valid_o, m.valid);
    chk({n, " ctrl"}, ex_ctrl_o, m.ctrl);
    chk({n, " pc"}, ex_pc_o, m.pc);
    chk({n, " rs_data"}, ex_rs_data_o, m.rsd);
    chk({n, " rt_data"}, ex_rt_data_o, m.rtd);
    chk({n, " imm"}, ex_imm_o, m.imm);
    chk({n, " rs"}, ex_rs_o, m.rs);
    chk({n, " rt"}, ex_rt_o, m.rt);
    chk({n, " dest"}, ex_dest_o, m.dest);
    chk({n, " bubble_cnt"}, bubble_cnt_o, m.cnt);
  endtask

  // called during the low phase with inputs applied; returns at the next negedge
  task automatic step(input string n);
    logic hz;
    #1;
    hz = m_hazard();
    chk({n, " stall_o"}, stall_o, !flush_i && (stall_i || hz));
    @(posedge clk);
    if (flush_i) begin
      m.valid = 0; m.ctrl = 0; m.dest = 0;
    end else if (stall_i) begin
    end else if (hz) begin
      m.valid = 0; m.ctrl = 0; m.dest = 0;
      if (m.cnt != 16'hFFFF) m.cnt = m.cnt + 1;
    end else begin
      m.valid = id_valid_i;
      m.ctrl = id_valid_i ? id_ctrl_i : 16'h0;
      m.dest = (id_valid_i && id_ctrl_i[9]) ? (id_ctrl_i[15] ? id_rd_i : id_rt_i) : 5'd0;
      m.pc = id_pc_i; m.rsd = id_rs_data_i; m.rtd = id_rt_data_i; m.imm = id_imm_i;
      m.rs = id_rs_i; m.rt = id_rt_i;
    end
    #1 check_state(n);
    @(negedge clk);
  endtask

  task automatic set_in(input logic v, input logic [15:0] c, input logic [31:0] pc,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic st, input logic fl);
    id_valid_i = v; id_ctrl_i = c; id_pc_i = pc; id_rs_i = rs; id_rt_i = rt; id_rd_i = rd;
    stall_i = st; flush_i = fl;
    id_rs_data_i = pc ^ 32'hA5A5_0000; id_rt_data_i = ~pc; id_imm_i = pc << 2;
  endtask

  // asynchronous reset asserted between edges, held over one edge, released at a negedge
  task automatic do_reset(input string n);
    #2 reset = 1'b1;
    #1 m_clear();
    check_state({n, " async"});
    @(posedge clk);
    #1 check_state({n, " held"});
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    tbl[0] = '{1'b1, ADD,  32'h10, 5'd1, 5'd2, 5'd3,  1'b0, 1'b0, 1'b1, 32'h10, 5'd3, 1'b0};
    tbl[1] = '{1'b1, ADDI, 32'h14, 5'd1, 5'd4, 5'd7,  1'b0, 1'b0, 1'b1, 32'h14, 5'd4, 1'b0};
    tbl[2] = '{1'b1, STW,  32'h18, 5'd4, 5'd5, 5'd9,  1'b0, 1'b0, 1'b1, 32'h18, 5'd0, 1'b0};
    tbl[3] = '{1'b1, ADD,  32'h1C, 5'd1, 5'd2, 5'd3,  1'b1, 1'b0, 1'b1, 32'h18, 5'd0, 1'b1};
    tbl[4] = '{1'b1, ADD,  32'h1C, 5'd1, 5'd2, 5'd3,  1'b0, 1'b1, 1'b0, 32'h18, 5'd0, 1'b0};
    tbl[5] = '{1'b0, ADD,  32'h20, 5'd1, 5'd2, 5'd6,  1'b0, 1'b0, 1'b0, 32'h20, 5'd0, 1'b0};
    tbl[6] = '{1'b1, ADD,  32'h24, 5'd3, 5'd4, 5'd0,  1'b0, 1'b0, 1'b1, 32'h24, 5'd0, 1'b0};
    tbl[7] = '{1'b1, ADD,  32'h28, 5'd3, 5'd4, 5'd31, 1'b1, 1'b1, 1'b0, 32'h24, 5'd0, 1'b0};
    tbl[8] = '{1'b1, ADDI, 32'h2C, 5'd3, 5'd8, 5'd9,  1'b0, 1'b0, 1'b1, 32'h2C, 5'd8, 1'b0};

    reset = 1'b1;
    set_in(1'b0, 16'h0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    m_clear();
    @(negedge clk);
    check_state("power-on reset");
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      set_in(tbl[i].v, tbl[i].ctrl, tbl[i].pc, tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].st, tbl[i].fl);
      #1 chk($sformatf("tbl%0d stall_o", i), stall_o, tbl[i].e_stall);
      step($sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d valid", i), ex_valid_o, tbl[i].e_valid);
      chk($sformatf("tbl%0d pc", i), ex_pc_o, tbl[i].e_pc);
      chk($sformatf("tbl%0d dest", i), ex_dest_o, tbl[i].e_dest);
    end

    // load r5 then dependent ADD: one bubble, ADD lands one edge later
    do_reset("r36 reset");
    set_in(1'b1, LDW, 32'h40, 5'd2, 5'd5, 5'd0, 1'b0, 1'b0);
    step("r36 ldw");
    set_in(1'b1, ADD, 32'h44, 5'd5, 5'd1, 5'd6, 1'b0, 1'b0);
    #1 chk("r36 stall_o", stall_o, HZ);
    step("r36 bubble");
    chk("r36 bubble valid", ex_valid_o, !HZ);
    chk("r36 bubble cnt", bubble_cnt_o, HZ);
    step("r36 add");
    chk("r36 add valid", ex_valid_o, 1'b1);
    chk("r36 add pc", ex_pc_o, 32'h44);
    chk("r36 add cnt", bubble_cnt_o, HZ);

    // r0 destination never hazards
    set_in(1'b1, LDW, 32'h50, 5'd2, 5'd0, 5'd0, 1'b0, 1'b0);
    step("r37 ldw r0");
    set_in(1'b1, ADD, 32'h54, 5'd0, 5'd0, 5'd7, 1'b0, 1'b0);
    #1 chk("r37 stall_o", stall_o, 1'b0);
    step("r37 add");
    chk("r37 valid", ex_valid_o, 1'b1);
    chk("r37 cnt", bubble_cnt_o, HZ);

    // flush beats stall and hazard
    set_in(1'b1, LDW, 32'h60, 5'd2, 5'd5, 5'd0, 1'b0, 1'b0);
    step("r38 ldw");
    set_in(1'b1, ADD, 32'h64, 5'd5, 5'd5, 5'd8, 1'b1, 1'b1);
    #1 chk("r38 stall_o", stall_o, 1'b0);
    step("r38 flush");
    chk("r38 valid", ex_valid_o, 1'b0);

    // three-cycle stall holds ADD at pc 0x40
    set_in(1'b1, ADD, 32'h40, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
    step("r39 load");
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, STW, 32'h100 + i, 5'd6, 5'd7, 5'd8, 1'b1, 1'b0);
      step($sformatf("r39 stall%0d", i));
      chk($sformatf("r39 pc%0d", i), ex_pc_o, 32'h40);
      chk($sformatf("r39 ctrl%0d", i), ex_ctrl_o, ADD);
    end

    // counter saturation: preload near the top, then keep generating hazards
    do_reset("r40 reset");
    set_in(1'b1, LDW, 32'h200, 5'd1, 5'd5, 5'd0, 1'b0, 1'b0);
    step("r40 ldw");
    force dut.bubble_cnt_o = 16'hFFFD;
    #1 release dut.bubble_cnt_o;
    m.cnt = HZ ? 16'hFFFD : 16'h0;
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, ADD, 32'h204, 5'd5, 5'd2, 5'd3, 1'b0, 1'b0);
      step($sformatf("r40 hz%0d", i));
      set_in(1'b1, LDW, 32'h208, 5'd1, 5'd5, 5'd0, 1'b0, 1'b0);
      step($sformatf("r40 reload%0d", i));
    end
    chk("r40 saturated", bubble_cnt_o, HZ ? 32'hFFFF : 32'h0);

    // reset between edges with a store in EX, then reset in the middle of a hazard
    set_in(1'b1, STW, 32'h300, 5'd3, 5'd4, 5'd0, 1'b0, 1'b0);
    step("r41 stw");
    do_reset("r41 reset stw");
    set_in(1'b1, LDW, 32'h310, 5'd1, 5'd6, 5'd0, 1'b0, 1'b0);
    step("r33 ldw");
    set_in(1'b1, ADD, 32'h314, 5'd6, 5'd1, 5'd2, 1'b0, 1'b0);
    do_reset("r33 reset");
    step("r33 after");
    chk("r33 add loaded", ex_valid_o, 1'b1);
    chk("r33 add pc", ex_pc_o, 32'h314);

    for (int i = 0; i < 400; i++) begin
      logic [15:0] c;
      case ($urandom_range(0, 4))
        0: c = ADD; 1: c = LDW; 2: c = STW; 3: c = ADDI; default: c = 16'($urandom);
      endcase
      set_in($urandom_range(0, 9) < 8, c, $urandom, 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0);
      id_rs_data_i = $urandom; id_rt_data_i = $urandom; id_imm_i = $urandom;
      if ($urandom_range(0, 49) == 0) do_reset($sformatf("rnd%0d reset", i));
      else step($sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
